grant_router: RTL and testbench

//  Consumer side of the round-robin request/grant arbiter. Takes the arbiter's encoded grant,

---
 rtl/grant_router_pkg.sv | 19 +
 rtl/grant_router_watchdog.sv | 27 ++
 rtl/grant_router.sv | 106 ++++++++++
 tb/tb_grant_router.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_router_pkg.sv
// Shared types for grant_router: FSM state encoding, memory-op encoding and the
// index-width helper shared with the companion round-robin arbiter.
package grant_router_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Encoded-grant width; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grant_router_watchdog.sv
// ISSUE-state watchdog for grant_router: counts cycles while run is high and
// flags expiry on the TIMEOUT_CYCLES-th cycle. Present only with GRANT_ROUTER_TIMEOUT_EN.
module grant_router_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Held at zero outside ISSUE, so every entry to ISSUE starts a fresh count.
  always_ff @(posedge clock) begin
    if (reset || !run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/grant_router.sv
// Consumer side of the round-robin arbiter: latches the granted requester's transaction,
// owns the shared memory port until completion, routes the response back to that owner.
// Optional ISSUE watchdog enabled by defining GRANT_ROUTER_TIMEOUT_EN.
module grant_router
  import grant_router_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [idx_bits(WIDTH)-1:0]     grant,
  input  logic [WIDTH-1:0]               req_read,
  input  logic [WIDTH-1:0]               req_write,
  input  logic [WIDTH*ADDR_WIDTH-1:0]    req_address,
  input  logic [WIDTH*DATA_WIDTH-1:0]    req_data,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_WIDTH-1:0]          mem_address,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic                           mem_ready,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  output logic [WIDTH-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_error,
  output logic                           busy
);

  localparam int IDX = idx_bits(WIDTH);
  localparam logic [WIDTH-1:0] ONE_HOT_BASE = WIDTH'(1);

  state_t          state;
  logic [IDX-1:0]  owner;
  logic            op;
  logic [WIDTH-1:0] reqs;
  logic            expired;

  assign reqs = req_read | req_write;

`ifdef GRANT_ROUTER_TIMEOUT_EN
  grant_router_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .run    (state == ISSUE),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= '0;
      op          <= OP_READ;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_error  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A grant pointing at an idle requester is stale; drop it and wait.
          if (reqs[grant]) begin
            owner       <= grant;
            op          <= req_write[grant] ? OP_WRITE : OP_READ;
            mem_read    <= !req_write[grant];
            mem_write   <= req_write[grant];
            mem_address <= req_address[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata   <= req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // A real completion beats a watchdog expiry landing on the same cycle.
          if (mem_ready || expired) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= ONE_HOT_BASE << owner;
            resp_data  <= (mem_ready && op == OP_READ) ? mem_rdata : '0;
            resp_error <= !mem_ready;
            state      <= RESPOND;
          end
        end
        RESPOND: begin
          resp_valid <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_router.sv
// Self-checking bench for grant_router: directed vector table, multi-cycle corner
// sequences and a randomized transaction-level model acting as arbiter and memory.
module tb_grant_router;

  localparam int WIDTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TO    = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic [1:0]         grant;
  logic [WIDTH-1:0]   req_read, req_write;
  logic [WIDTH*AW-1:0] req_address;
  logic [WIDTH*DW-1:0] req_data;
  logic               mem_read, mem_write;
  logic [AW-1:0]      mem_address;
  logic [DW-1:0]      mem_wdata;
  logic               mem_ready;
  logic [DW-1:0]      mem_rdata;
  logic [WIDTH-1:0]   resp_valid;
  logic [DW-1:0]      resp_data;
  logic               resp_error;
  logic               busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  grant_router #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .grant(grant),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error), .busy(busy)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [1:0]  g;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_r;
    logic        exp_w;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] d);
    req_address[i*AW +: AW] = a;
    req_data[i*DW +: DW]    = d;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_rv"}, resp_valid, 4'b0000);
    check({name, "_op"}, {mem_read, mem_write}, 2'b00);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // Entered and left at a negedge with the router idle.
  task automatic run_txn(input vec_t v);
    int g;
    g = int'(v.g);
    set_slot(g, v.addr, v.wdata);
    req_read  = req_read | v.rd;
    req_write = req_write | v.wr;
    grant     = v.g;
    @(negedge clock);
    check("issue_op", {mem_read, mem_write}, {v.exp_r, v.exp_w});
    check("issue_addr", mem_address, v.addr);
    if (v.exp_w) check("issue_wdata", mem_wdata, v.wdata);
    check("issue_busy", busy, 1'b1);
    set_slot(g, $urandom, $urandom);
    for (int k = 0; k < v.delay; k++) begin
      @(negedge clock);
      check("hold_op", {mem_read, mem_write}, {v.exp_r, v.exp_w});
      check("hold_addr", mem_address, v.addr);
      check("hold_rv", resp_valid, 4'b0000);
    end
    mem_ready = 1'b1;
    mem_rdata = v.rdata;
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    check("resp_valid", resp_valid, v.exp_rv);
    check("resp_data", resp_data, v.exp_rdata);
    check("resp_error", resp_error, 1'b0);
    check("resp_op_dropped", {mem_read, mem_write}, 2'b00);
    req_read[g]  = 1'b0;
    req_write[g] = 1'b0;
    @(negedge clock);
    check("after_resp_rv", resp_valid, 4'b0000);
    check("after_resp_busy", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  logic        pend_r[4];
  logic        pend_w[4];
  logic [31:0] pend_a[4];
  logic [31:0] pend_d[4];

  initial begin
    vec_t v;
    vecs[0] = '{rd: 4'b0100, wr: 4'b0000, g: 2'd2, addr: 32'h100, wdata: 32'h0, delay: 3,
                rdata: 32'hCAFE, exp_r: 1'b1, exp_w: 1'b0, exp_rv: 4'b0100, exp_rdata: 32'hCAFE};
    vecs[1] = '{rd: 4'b0000, wr: 4'b0010, g: 2'd1, addr: 32'h40, wdata: 32'h55AA, delay: 2,
                rdata: 32'h1234, exp_r: 1'b0, exp_w: 1'b1, exp_rv: 4'b0010, exp_rdata: 32'h0};
    vecs[2] = '{rd: 4'b1000, wr: 4'b1000, g: 2'd3, addr: 32'h80, wdata: 32'hBEEF, delay: 1,
                rdata: 32'h9999, exp_r: 1'b0, exp_w: 1'b1, exp_rv: 4'b1000, exp_rdata: 32'h0};
    vecs[3] = '{rd: 4'b0001, wr: 4'b0000, g: 2'd0, addr: 32'hFFFF_FFFC, wdata: 32'h0, delay: 0,
                rdata: 32'hFFFF_FFFF, exp_r: 1'b1, exp_w: 1'b0, exp_rv: 4'b0001, exp_rdata: 32'hFFFF_FFFF};
    vecs[4] = '{rd: 4'b0000, wr: 4'b0001, g: 2'd0, addr: 32'h0, wdata: 32'hFFFF_FFFF, delay: 5,
                rdata: 32'h7777, exp_r: 1'b0, exp_w: 1'b1, exp_rv: 4'b0001, exp_rdata: 32'h0};

    reset = 1'b1; grant = '0; req_read = '0; req_write = '0;
    req_address = '0; req_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clock);
    check("rst_mem_op", {mem_read, mem_write}, 2'b00);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_resp", {resp_valid, resp_data, resp_error}, 37'h0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Reset held three cycles in the middle of ISSUE.
    set_slot(1, 32'h300, 32'h0);
    req_read = 4'b0010; grant = 2'd1;
    @(negedge clock);
    check("pre_rst_issue", mem_read, 1'b1);
    @(negedge clock);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_quiet("mid_rst");
      check("mid_rst_addr", mem_address, 32'h0);
    end
    reset = 1'b0; mem_ready = 1'b0; req_read = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check_quiet("post_rst");
    end

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Stale grant: requester 0 pending, grant points at idle requester 3.
    set_slot(0, 32'h500, 32'h0);
    req_read = 4'b0001; grant = 2'd3;
    repeat (2) begin
      @(negedge clock);
      check_quiet("stale_grant");
    end
    v = '{rd: 4'b0001, wr: 4'b0000, g: 2'd0, addr: 32'h500, wdata: 32'h0, delay: 1,
          rdata: 32'h5050, exp_r: 1'b1, exp_w: 1'b0, exp_rv: 4'b0001, exp_rdata: 32'h5050};
    run_txn(v);

    // mem_ready while idle is ignored.
    mem_ready = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clock);
    mem_ready = 1'b0;
    @(negedge clock);
    check_quiet("stray_ready");

    // Contention: all four reading, grant rotates 0..3.
    for (int i = 0; i < 4; i++) set_slot(i, 32'h1000 + 32'(i) * 32'h10, 32'h0);
    req_read = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      v = '{rd: 4'b0000, wr: 4'b0000, g: 2'(i), addr: 32'h1000 + 32'(i) * 32'h10, wdata: 32'h0,
            delay: i, rdata: 32'hA000 + 32'(i), exp_r: 1'b1, exp_w: 1'b0,
            exp_rv: 4'b0001 << i, exp_rdata: 32'hA000 + 32'(i)};
      run_txn(v);
    end
    check("contention_drained", {req_read, req_write}, 8'h00);

`ifdef GRANT_ROUTER_TIMEOUT_EN
    set_slot(2, 32'h200, 32'h0);
    req_read = 4'b0100; grant = 2'd2;
    @(negedge clock);
    check("to_issue", mem_read, 1'b1);
    for (int k = 1; k < TO; k++) begin
      @(negedge clock);
      check("to_hold", {mem_read, resp_valid}, {1'b1, 4'b0000});
    end
    @(negedge clock);
    check("to_resp_valid", resp_valid, 4'b0100);
    check("to_resp_error", resp_error, 1'b1);
    check("to_resp_data", resp_data, 32'h0);
    check("to_op_dropped", mem_read, 1'b0);
    req_read = '0;
    @(negedge clock);
    check_quiet("to_after");
`else
    set_slot(2, 32'h200, 32'h0);
    req_read = 4'b0100; grant = 2'd2;
    repeat (40) @(negedge clock);
    check("stall_busy", busy, 1'b1);
    check("stall_op", mem_read, 1'b1);
    check("stall_rv", resp_valid, 4'b0000);
    reset = 1'b1; req_read = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_quiet("stall_recover");
`endif

    // Randomized traffic against a transaction-level model.
    for (int i = 0; i < 4; i++) begin
      pend_r[i] = 1'b0; pend_w[i] = 1'b0;
    end
    for (int it = 0; it < 150; it++) begin
      logic any;
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!(pend_r[i] || pend_w[i]) && ($urandom_range(1, 0) == 1 || (i == 3 && !any))) begin
          int kind;
          kind = $urandom_range(2, 0);
          pend_r[i] = (kind != 1);
          pend_w[i] = (kind != 0);
          pend_a[i] = $urandom;
          pend_d[i] = $urandom;
          set_slot(i, pend_a[i], pend_d[i]);
        end
        any = any || pend_r[i] || pend_w[i];
      end
      for (int i = 0; i < 4; i++) begin
        req_read[i]  = pend_r[i];
        req_write[i] = pend_w[i];
      end
      for (int attempt = 0; attempt < 20; attempt++) begin
        int g;
        g = $urandom_range(3, 0);
        if (pend_r[g] || pend_w[g]) begin
          logic [31:0] rd;
          rd = $urandom;
          v = '{rd: 4'b0000, wr: 4'b0000, g: 2'(g), addr: pend_a[g], wdata: pend_d[g],
                delay: $urandom_range(5, 0), rdata: rd, exp_r: !pend_w[g], exp_w: pend_w[g],
                exp_rv: 4'b0001 << g, exp_rdata: pend_w[g] ? 32'h0 : rd};
          run_txn(v);
          pend_r[g] = 1'b0;
          pend_w[g] = 1'b0;
          break;
        end else begin
          grant     = 2'(g);
          mem_ready = 1'($urandom_range(1, 0));
          mem_rdata = $urandom;
          @(negedge clock);
          mem_ready = 1'b0;
          check_quiet("rand_stale");
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
